// File: rtl/axi_mem_bridge_pkg.sv
// Shared encodings for the cache-to-AXI bridge: widths, IDs, burst type, FSM states.
package axi_mem_bridge_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned LEN_W    = 8;
    localparam int unsigned SIZE_W   = 3;
    localparam int unsigned ID_W     = 4;
    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned LINE_LSB = 6;

    localparam logic [ID_W-1:0] ICACHE_ID = 4'd0;
    localparam logic [ID_W-1:0] DCACHE_ID = 4'd1;

    localparam logic [1:0] BURST_INCR = 2'b01;

    localparam logic [1:0] RD_IDLE = 2'd0;
    localparam logic [1:0] RD_ADDR = 2'd1;
    localparam logic [1:0] RD_DATA = 2'd2;

    localparam logic [1:0] WR_IDLE = 2'd0;
    localparam logic [1:0] WR_ADDR = 2'd1;
    localparam logic [1:0] WR_DATA = 2'd2;
    localparam logic [1:0] WR_RESP = 2'd3;

    // Latched AR/AW address-phase payload
    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [SIZE_W-1:0] size;
    } ax_req_t;

endpackage

// File: rtl/axi_mem_bridge_rd_arbiter.sv
// Read side: dcache-priority arbitration, RAW hold-off against the active write, AR/R sequencing.
module axi_rd_arbiter
    import axi_mem_bridge_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_r_req,
    input  logic [ADDR_W-1:0]        i_r_addr,
    input  logic [SIZE_W-1:0]        i_r_size,
    input  logic [LEN_W-1:0]         i_r_length,
    input  logic                     i_r_data_ready,
    output logic                     i_r_rdy,
    output logic                     i_ret_valid,
    output logic                     i_ret_last,
    output logic [DATA_W-1:0]        i_r_data,
    input  logic                     d_r_req,
    input  logic [ADDR_W-1:0]        d_r_addr,
    input  logic [SIZE_W-1:0]        d_r_size,
    input  logic [LEN_W-1:0]         d_r_length,
    input  logic                     d_r_data_ready,
    output logic                     d_r_rdy,
    output logic                     d_ret_valid,
    output logic                     d_ret_last,
    output logic [DATA_W-1:0]        d_r_data,
    input  logic                     wr_busy,
    input  logic [ADDR_W-1:LINE_LSB] wr_line,
    output logic [ID_W-1:0]          arid,
    output logic [ADDR_W-1:0]        araddr,
    output logic [LEN_W-1:0]         arlen,
    output logic [SIZE_W-1:0]        arsize,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [ID_W-1:0]          rid,
    input  logic [DATA_W-1:0]        rdata,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    ax_req_t    ar_q;
    logic       owner_d;
    logic       d_blocked;
    logic       d_grant;
    logic       i_grant;
    logic       id_match;
    logic       owner_ready;
    logic       in_data;

    // A dcache read may not overtake a pending write to the same line
    assign d_blocked   = wr_busy && (d_r_addr[ADDR_W-1:LINE_LSB] == wr_line);
    assign d_grant     = !rst && (state == RD_IDLE) && d_r_req && !d_blocked;
    assign i_grant     = !rst && (state == RD_IDLE) && i_r_req && !d_grant;
    assign in_data     = (state == RD_DATA);
    assign id_match    = (rid == ar_q.id);
    assign owner_ready = owner_d ? d_r_data_ready : i_r_data_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RD_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RD_IDLE: if (d_grant || i_grant)           state_nxt = RD_ADDR;
            RD_ADDR: if (arready)                      state_nxt = RD_DATA;
            RD_DATA: if (rvalid && rready && rlast)    state_nxt = RD_IDLE;
            default:                                   state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_q    <= '0;
            owner_d <= 1'b0;
        end else if (d_grant) begin
            ar_q    <= '{id: DCACHE_ID, addr: d_r_addr, len: d_r_length, size: d_r_size};
            owner_d <= 1'b1;
        end else if (i_grant) begin
            ar_q    <= '{id: ICACHE_ID, addr: i_r_addr, len: i_r_length, size: i_r_size};
            owner_d <= 1'b0;
        end
    end

    assign d_r_rdy = d_grant;
    assign i_r_rdy = i_grant;

    assign arvalid = (state == RD_ADDR);
    assign arid    = ar_q.id;
    assign araddr  = ar_q.addr;
    assign arlen   = ar_q.len;
    assign arsize  = ar_q.size;

    // A beat tagged with a foreign rid is never accepted
    assign rready      = in_data && id_match && owner_ready;
    assign d_ret_valid = in_data && rvalid && id_match && owner_d;
    assign i_ret_valid = in_data && rvalid && id_match && !owner_d;
    assign d_ret_last  = d_ret_valid && rlast;
    assign i_ret_last  = i_ret_valid && rlast;
    assign d_r_data    = rdata;
    assign i_r_data    = rdata;

endmodule

// File: rtl/axi_mem_bridge.sv
// Merges icache reads and dcache reads/writes onto one AXI4 master; write path lives here.
module axi_mem_bridge
    import axi_mem_bridge_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_r_req,
    input  logic [31:0]       i_r_addr,
    input  logic [2:0]        i_r_size,
    input  logic [7:0]        i_r_length,
    input  logic              i_r_data_ready,
    output logic              i_r_rdy,
    output logic              i_ret_valid,
    output logic              i_ret_last,
    output logic [31:0]       i_r_data,
    input  logic              d_r_req,
    input  logic [31:0]       d_r_addr,
    input  logic [2:0]        d_r_size,
    input  logic [7:0]        d_r_length,
    input  logic              d_r_data_ready,
    output logic              d_r_rdy,
    output logic              d_ret_valid,
    output logic              d_ret_last,
    output logic [31:0]       d_r_data,
    input  logic              d_w_req,
    input  logic [31:0]       d_w_addr,
    input  logic [2:0]        d_w_size,
    input  logic [7:0]        d_w_length,
    input  logic [3:0]        d_w_strb,
    input  logic              d_w_data_req,
    input  logic              d_w_last,
    input  logic [31:0]       d_w_data,
    input  logic              d_b_ready,
    output logic              d_w_rdy,
    output logic              d_w_data_ready,
    output logic              d_b_valid,
    output logic [3:0]        arid,
    output logic [31:0]       araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arlock,
    output logic [3:0]        arcache,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    input  logic [3:0]        rid,
    input  logic [31:0]       rdata,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic [3:0]        awid,
    output logic [31:0]       awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              awlock,
    output logic [3:0]        awcache,
    output logic [2:0]        awprot,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [3:0]        bid,
    input  logic              bvalid,
    output logic              bready
);

    logic [1:0]       wr_state;
    logic [1:0]       wr_state_nxt;
    ax_req_t          aw_q;
    logic [LEN_W-1:0] beat_cnt;
    logic             w_accept;
    logic             w_fire;
    logic             b_match;
    logic             b_fire;

    axi_rd_arbiter u_rd (
        .clk            (clk),
        .rst            (rst),
        .i_r_req        (i_r_req),
        .i_r_addr       (i_r_addr),
        .i_r_size       (i_r_size),
        .i_r_length     (i_r_length),
        .i_r_data_ready (i_r_data_ready),
        .i_r_rdy        (i_r_rdy),
        .i_ret_valid    (i_ret_valid),
        .i_ret_last     (i_ret_last),
        .i_r_data       (i_r_data),
        .d_r_req        (d_r_req),
        .d_r_addr       (d_r_addr),
        .d_r_size       (d_r_size),
        .d_r_length     (d_r_length),
        .d_r_data_ready (d_r_data_ready),
        .d_r_rdy        (d_r_rdy),
        .d_ret_valid    (d_ret_valid),
        .d_ret_last     (d_ret_last),
        .d_r_data       (d_r_data),
        .wr_busy        (wr_state != WR_IDLE),
        .wr_line        (aw_q.addr[ADDR_W-1:LINE_LSB]),
        .arid           (arid),
        .araddr         (araddr),
        .arlen          (arlen),
        .arsize         (arsize),
        .arvalid        (arvalid),
        .arready        (arready),
        .rid            (rid),
        .rdata          (rdata),
        .rlast          (rlast),
        .rvalid         (rvalid),
        .rready         (rready)
    );

    assign arburst = BURST_INCR;
    assign arlock  = 1'b0;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign awburst = BURST_INCR;
    assign awlock  = 1'b0;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;

    assign w_accept = !rst && (wr_state == WR_IDLE) && d_w_req;
    assign w_fire   = wvalid && wready;
    // Responses carrying another master's ID are left on the bus
    assign b_match  = (bid == aw_q.id);
    assign b_fire   = bvalid && bready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wr_state <= WR_IDLE;
        else     wr_state <= wr_state_nxt;
    end

    always_comb begin
        wr_state_nxt = wr_state;
        case (wr_state)
            WR_IDLE: if (w_accept)         wr_state_nxt = WR_ADDR;
            WR_ADDR: if (awready)          wr_state_nxt = WR_DATA;
            WR_DATA: if (w_fire && wlast)  wr_state_nxt = WR_RESP;
            WR_RESP: if (b_fire)           wr_state_nxt = WR_IDLE;
            default:                       wr_state_nxt = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_q     <= '0;
            beat_cnt <= '0;
        end else if (w_accept) begin
            aw_q     <= '{id: DCACHE_ID, addr: d_w_addr, len: d_w_length, size: d_w_size};
            beat_cnt <= '0;
        end else if (w_fire) begin
            beat_cnt <= beat_cnt + LEN_W'(1);
        end
    end

    assign d_w_rdy = w_accept;

    assign awvalid = (wr_state == WR_ADDR);
    assign awid    = aw_q.id;
    assign awaddr  = aw_q.addr;
    assign awlen   = aw_q.len;
    assign awsize  = aw_q.size;

    // Final beat is flagged by the cache or forced once awlen+1 beats have gone out
    assign wvalid         = (wr_state == WR_DATA) && d_w_data_req;
    assign wlast          = (wr_state == WR_DATA) && (d_w_last || (beat_cnt == aw_q.len));
    assign wdata          = d_w_data;
    assign wstrb          = d_w_strb;
    assign d_w_data_ready = (wr_state == WR_DATA) && wready;

    assign d_b_valid = (wr_state == WR_RESP) && b_match && bvalid;
    assign bready    = (wr_state == WR_RESP) && b_match && d_b_ready;

endmodule

// File: tb/tb_axi_mem_bridge.sv
// Directed bench for axi_mem_bridge: tabled read/write transactions plus overlap and reset sequences.
module tb_axi_mem_bridge;
    import axi_mem_bridge_pkg::*;

    logic        clk, rst;
    logic        i_r_req, i_r_data_ready, i_r_rdy, i_ret_valid, i_ret_last;
    logic [31:0] i_r_addr, i_r_data;
    logic [2:0]  i_r_size;
    logic [7:0]  i_r_length;
    logic        d_r_req, d_r_data_ready, d_r_rdy, d_ret_valid, d_ret_last;
    logic [31:0] d_r_addr, d_r_data;
    logic [2:0]  d_r_size;
    logic [7:0]  d_r_length;
    logic        d_w_req, d_w_data_req, d_w_last, d_b_ready;
    logic [31:0] d_w_addr, d_w_data;
    logic [2:0]  d_w_size;
    logic [7:0]  d_w_length;
    logic [3:0]  d_w_strb;
    logic        d_w_rdy, d_w_data_ready, d_b_valid;
    logic [3:0]  arid, awid, rid, bid, arcache, awcache, wstrb;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst;
    logic        arlock, awlock, arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    axi_mem_bridge dut (
        .clk(clk), .rst(rst),
        .i_r_req(i_r_req), .i_r_addr(i_r_addr), .i_r_size(i_r_size), .i_r_length(i_r_length),
        .i_r_data_ready(i_r_data_ready), .i_r_rdy(i_r_rdy), .i_ret_valid(i_ret_valid),
        .i_ret_last(i_ret_last), .i_r_data(i_r_data),
        .d_r_req(d_r_req), .d_r_addr(d_r_addr), .d_r_size(d_r_size), .d_r_length(d_r_length),
        .d_r_data_ready(d_r_data_ready), .d_r_rdy(d_r_rdy), .d_ret_valid(d_ret_valid),
        .d_ret_last(d_ret_last), .d_r_data(d_r_data),
        .d_w_req(d_w_req), .d_w_addr(d_w_addr), .d_w_size(d_w_size), .d_w_length(d_w_length),
        .d_w_strb(d_w_strb), .d_w_data_req(d_w_data_req), .d_w_last(d_w_last),
        .d_w_data(d_w_data), .d_b_ready(d_b_ready), .d_w_rdy(d_w_rdy),
        .d_w_data_ready(d_w_data_ready), .d_b_valid(d_b_valid),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bvalid(bvalid), .bready(bready)
    );

    typedef struct {
        logic        dside;
        logic [31:0] addr;
        logic [7:0]  len;
        int          ar_wait;
    } rd_vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [3:0]  strb;
        int          stall;
        logic        give_last;
        logic        raw_probe;
    } wr_vec_t;

    rd_vec_t rd_vecs[3];
    wr_vec_t wr_vecs[3];
    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ar_phase(input logic [31:0] addr, input logic [7:0] len,
                            input logic [3:0] id, input int waits);
        for (int k = 0; k < waits; k++) begin
            arready = 1'b0;
            #1;
            chk("arvalid_hold", 32'(arvalid), 32'd1);
            chk("araddr_hold", araddr, addr);
            tick();
        end
        arready = 1'b1;
        #1;
        chk("arvalid", 32'(arvalid), 32'd1);
        chk("araddr", araddr, addr);
        chk("arlen", 32'(arlen), 32'(len));
        chk("arid", 32'(arid), 32'(id));
        chk("arsize", 32'(arsize), 32'd2);
        chk("arburst", 32'(arburst), 32'd1);
        tick();
        arready = 1'b0;
    endtask

    task automatic r_phase(input logic dside, input logic [3:0] id,
                           input logic [7:0] len, input logic [31:0] base);
        for (int b = 0; b <= int'(len); b++) begin
            rvalid = 1'b1;
            rid    = id;
            rdata  = base + 32'(b);
            rlast  = (b == int'(len));
            #1;
            chk("rready", 32'(rready), 32'd1);
            chk("ret_valid", 32'(dside ? d_ret_valid : i_ret_valid), 32'd1);
            chk("ret_other", 32'(dside ? i_ret_valid : d_ret_valid), 32'd0);
            chk("ret_last", 32'(dside ? d_ret_last : i_ret_last), 32'(b == int'(len)));
            chk("ret_data", dside ? d_r_data : i_r_data, base + 32'(b));
            chk("rdy_busy", 32'(i_r_rdy | d_r_rdy), 32'd0);
            tick();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        #1;
        chk("r_done_ret", 32'(i_ret_valid | d_ret_valid), 32'd0);
        chk("r_done_arvalid", 32'(arvalid), 32'd0);
    endtask

    task automatic do_read(input rd_vec_t v);
        logic [3:0] id;
        id = v.dside ? DCACHE_ID : ICACHE_ID;
        if (v.dside) begin
            d_r_req = 1'b1; d_r_addr = v.addr; d_r_length = v.len; d_r_size = 3'd2;
        end else begin
            i_r_req = 1'b1; i_r_addr = v.addr; i_r_length = v.len; i_r_size = 3'd2;
        end
        #1;
        chk("rd_grant", 32'(v.dside ? d_r_rdy : i_r_rdy), 32'd1);
        chk("rd_grant_other", 32'(v.dside ? i_r_rdy : d_r_rdy), 32'd0);
        tick();
        #1;
        // request still held: a second grant would be a bug
        chk("rd_grant_once", 32'(d_r_rdy | i_r_rdy), 32'd0);
        d_r_req = 1'b0;
        i_r_req = 1'b0;
        ar_phase(v.addr, v.len, id, v.ar_wait);
        r_phase(v.dside, id, v.len, v.addr);
    endtask

    task automatic do_write(input wr_vec_t v);
        logic [31:0] rd_addr;
        logic [31:0] wd;
        rd_addr = v.addr + 32'd4;
        d_w_req = 1'b1; d_w_addr = v.addr; d_w_length = v.len; d_w_size = 3'd2;
        d_w_strb = v.strb; d_b_ready = 1'b1; bid = DCACHE_ID;
        #1;
        chk("w_accept", 32'(d_w_rdy), 32'd1);
        tick();
        d_w_req = 1'b0;
        awready = 1'b1;
        #1;
        chk("awvalid", 32'(awvalid), 32'd1);
        chk("awaddr", awaddr, v.addr);
        chk("awlen", 32'(awlen), 32'(v.len));
        chk("awid", 32'(awid), 32'(DCACHE_ID));
        chk("awsize", 32'(awsize), 32'd2);
        chk("awburst", 32'(awburst), 32'd1);
        tick();
        awready = 1'b0;
        if (v.raw_probe) begin
            d_r_req = 1'b1; d_r_addr = rd_addr; d_r_length = 8'd0; d_r_size = 3'd2;
        end
        for (int b = 0; b <= int'(v.len); b++) begin
            wd           = 32'hA500_0000 + 32'(b);
            d_w_data_req = 1'b1;
            d_w_data     = wd;
            d_w_last     = v.give_last && (b == int'(v.len));
            for (int s = 0; s < ((b == 0) ? v.stall : 0); s++) begin
                wready = 1'b0;
                #1;
                chk("wvalid_stall", 32'(wvalid), 32'd1);
                chk("wdata_stall", wdata, wd);
                chk("wlast_stall", 32'(wlast), 32'(b == int'(v.len)));
                chk("wready_fwd_stall", 32'(d_w_data_ready), 32'd0);
                if (v.raw_probe) chk("raw_block", 32'(d_r_rdy), 32'd0);
                tick();
            end
            wready = 1'b1;
            #1;
            chk("wvalid", 32'(wvalid), 32'd1);
            chk("wdata", wdata, wd);
            chk("wstrb", 32'(wstrb), 32'(v.strb));
            chk("wlast", 32'(wlast), 32'(b == int'(v.len)));
            chk("wready_fwd", 32'(d_w_data_ready), 32'd1);
            if (v.raw_probe) chk("raw_block", 32'(d_r_rdy), 32'd0);
            tick();
        end
        d_w_data_req = 1'b0; wready = 1'b0; d_w_last = 1'b0;
        bvalid = 1'b0;
        #1;
        chk("b_wait", 32'(d_b_valid), 32'd0);
        chk("bready", 32'(bready), 32'd1);
        chk("wvalid_done", 32'(wvalid), 32'd0);
        if (v.raw_probe) chk("raw_block_resp", 32'(d_r_rdy), 32'd0);
        tick();
        bvalid = 1'b1;
        #1;
        chk("b_fwd", 32'(d_b_valid), 32'd1);
        if (v.raw_probe) chk("raw_block_hs", 32'(d_r_rdy), 32'd0);
        tick();
        bvalid = 1'b0;
        #1;
        chk("w_idle", 32'(awvalid | wvalid | bready), 32'd0);
        if (v.raw_probe) begin
            chk("raw_release", 32'(d_r_rdy), 32'd1);
            tick();
            d_r_req = 1'b0;
            ar_phase(rd_addr, 8'd0, DCACHE_ID, 0);
            r_phase(1'b1, DCACHE_ID, 8'd0, rd_addr);
        end
    endtask

    initial begin
        rd_vecs[0] = '{dside: 1'b0, addr: 32'h1C00_0040, len: 8'd15, ar_wait: 2};
        rd_vecs[1] = '{dside: 1'b1, addr: 32'h0000_0080, len: 8'd3,  ar_wait: 0};
        rd_vecs[2] = '{dside: 1'b0, addr: 32'h0000_0100, len: 8'd0,  ar_wait: 1};
        wr_vecs[0] = '{addr: 32'h0000_1000, len: 8'd15, strb: 4'hF, stall: 0, give_last: 1'b1, raw_probe: 1'b1};
        wr_vecs[1] = '{addr: 32'h0000_4010, len: 8'd0,  strb: 4'b0011, stall: 3, give_last: 1'b1, raw_probe: 1'b0};
        wr_vecs[2] = '{addr: 32'h0000_5000, len: 8'd3,  strb: 4'hF, stall: 0, give_last: 1'b0, raw_probe: 1'b0};

        rst = 1'b1;
        i_r_req = 1'b1; i_r_addr = '0; i_r_size = '0; i_r_length = '0; i_r_data_ready = 1'b1;
        d_r_req = 1'b0; d_r_addr = '0; d_r_size = '0; d_r_length = '0; d_r_data_ready = 1'b1;
        d_w_req = 1'b1; d_w_addr = '0; d_w_size = '0; d_w_length = '0; d_w_strb = '0;
        d_w_data_req = 1'b0; d_w_last = 1'b0; d_w_data = '0; d_b_ready = 1'b0;
        arready = 1'b0; rid = '0; rdata = '0; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = '0; bvalid = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_awvalid", 32'(awvalid), 32'd0);
        chk("rst_rready", 32'(rready | bready), 32'd0);
        chk("rst_i_r_rdy", 32'(i_r_rdy), 32'd0);
        chk("rst_d_w_rdy", 32'(d_w_rdy), 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_awaddr", awaddr, 32'd0);
        i_r_req = 1'b0;
        d_w_req = 1'b0;
        rst = 1'b0;
        tick();

        foreach (rd_vecs[i]) do_read(rd_vecs[i]);

        // simultaneous requests: dcache first, icache the cycle after its rlast
        d_r_req = 1'b1; d_r_addr = 32'h0000_0200; d_r_length = 8'd1; d_r_size = 3'd2;
        i_r_req = 1'b1; i_r_addr = 32'h0000_0300; i_r_length = 8'd0; i_r_size = 3'd2;
        #1;
        chk("prio_d_rdy", 32'(d_r_rdy), 32'd1);
        chk("prio_i_wait", 32'(i_r_rdy), 32'd0);
        tick();
        d_r_req = 1'b0;
        ar_phase(32'h0000_0200, 8'd1, DCACHE_ID, 0);
        r_phase(1'b1, DCACHE_ID, 8'd1, 32'h0000_0200);
        chk("prio_i_after", 32'(i_r_rdy), 32'd1);
        tick();
        i_r_req = 1'b0;
        ar_phase(32'h0000_0300, 8'd0, ICACHE_ID, 0);
        r_phase(1'b0, ICACHE_ID, 8'd0, 32'h0000_0300);

        foreach (wr_vecs[i]) do_write(wr_vecs[i]);

        // refill of 0x2000 running alongside a writeback of 0x3000
        d_w_req = 1'b1; d_w_addr = 32'h0000_3000; d_w_length = 8'd3; d_w_strb = 4'hF; d_w_size = 3'd2;
        d_r_req = 1'b1; d_r_addr = 32'h0000_2000; d_r_length = 8'd3; d_r_size = 3'd2;
        #1;
        chk("ovl_w_rdy", 32'(d_w_rdy), 32'd1);
        chk("ovl_r_rdy", 32'(d_r_rdy), 32'd1);
        tick();
        d_w_req = 1'b0; d_r_req = 1'b0;
        arready = 1'b1; awready = 1'b1;
        #1;
        chk("ovl_arvalid", 32'(arvalid), 32'd1);
        chk("ovl_awvalid", 32'(awvalid), 32'd1);
        chk("ovl_araddr", araddr, 32'h0000_2000);
        chk("ovl_awaddr", awaddr, 32'h0000_3000);
        tick();
        arready = 1'b0; awready = 1'b0;
        rvalid = 1'b1; rid = ICACHE_ID; rdata = 32'h0000_DEAD; rlast = 1'b0;
        #1;
        chk("bad_rid_rready", 32'(rready), 32'd0);
        chk("bad_rid_ret", 32'(d_ret_valid | i_ret_valid), 32'd0);
        tick();
        rid = DCACHE_ID; d_r_data_ready = 1'b0; i_r_data_ready = 1'b1;
        #1;
        chk("owner_ready_rready", 32'(rready), 32'd0);
        tick();
        d_r_data_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            rvalid = 1'b1; rid = DCACHE_ID; rdata = 32'h0000_2000 + 32'(b); rlast = (b == 3);
            d_w_data_req = 1'b1; d_w_data = 32'h0000_B000 + 32'(b); d_w_last = (b == 3); wready = 1'b1;
            #1;
            chk("ovl_d_ret", 32'(d_ret_valid), 32'd1);
            chk("ovl_i_ret", 32'(i_ret_valid), 32'd0);
            chk("ovl_rdata", d_r_data, 32'h0000_2000 + 32'(b));
            chk("ovl_rready", 32'(rready), 32'd1);
            chk("ovl_wvalid", 32'(wvalid), 32'd1);
            chk("ovl_wdata", wdata, 32'h0000_B000 + 32'(b));
            chk("ovl_wlast", 32'(wlast), 32'(b == 3));
            tick();
        end
        rvalid = 1'b0; rlast = 1'b0; d_w_data_req = 1'b0; d_w_last = 1'b0; wready = 1'b0;
        bvalid = 1'b1;
        #1;
        chk("ovl_b_fwd", 32'(d_b_valid), 32'd1);
        chk("ovl_rd_idle", 32'(arvalid | rready), 32'd0);
        tick();
        bvalid = 1'b0;

        // reset in the middle of an 8-beat icache burst
        i_r_req = 1'b1; i_r_addr = 32'h0000_0400; i_r_length = 8'd7; i_r_size = 3'd2;
        #1;
        chk("mid_rst_grant", 32'(i_r_rdy), 32'd1);
        tick();
        i_r_req = 1'b0;
        ar_phase(32'h0000_0400, 8'd7, ICACHE_ID, 0);
        for (int b = 0; b < 3; b++) begin
            rvalid = 1'b1; rid = ICACHE_ID; rdata = 32'h0000_0400 + 32'(b); rlast = 1'b0;
            #1;
            chk("mid_rst_beat", 32'(i_ret_valid), 32'd1);
            tick();
        end
        rvalid = 1'b1; rdata = 32'h0000_0403; i_r_req = 1'b1; d_w_req = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_now_ret", 32'(i_ret_valid), 32'd0);
        chk("rst_now_rready", 32'(rready), 32'd0);
        chk("rst_now_arvalid", 32'(arvalid), 32'd0);
        chk("rst_now_araddr", araddr, 32'd0);
        chk("rst_now_arlen", 32'(arlen), 32'd0);
        chk("rst_now_rdy", 32'(i_r_rdy | d_w_rdy), 32'd0);
        tick();
        rvalid = 1'b0; i_r_req = 1'b0; d_w_req = 1'b0;
        rst = 1'b0;
        tick();
        do_read(rd_vecs[2]);
        do_read(rd_vecs[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_mem_bridge.md
Name: axi_mem_bridge

Overview:
- Sits directly downstream of the data cache and the instruction cache.
- Merges the icache read channel and the dcache read and write channels into one AXI4 master port toward the SoC interconnect.
- Handles read arbitration, AR/R and AW/W/B sequencing, and read-after-write ordering, so each cache sees its simple req/rdy/ret handshake.

Parameters:
- ICACHE_ID, 4'd0, ARID tag for icache reads.
- DCACHE_ID, 4'd1, ARID/AWID tag for dcache traffic.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- i_r_req, i_r_addr, i_r_size, i_r_length  in  1/32/3/8  icache read request.
- i_r_data_ready  in  1  icache can take beats.
- i_r_rdy  out  1  icache request accepted, 1-cycle pulse.
- i_ret_valid, i_ret_last, i_r_data  out  1/1/32  icache return beats.
- d_r_req, d_r_addr, d_r_size, d_r_length, d_r_data_ready  in  1/32/3/8/1  dcache read side.
- d_r_rdy, d_ret_valid, d_ret_last, d_r_data  out  1/1/1/32  dcache read responses.
- d_w_req, d_w_addr, d_w_size, d_w_length, d_w_strb  in  1/32/3/8/4  dcache write request.
- d_w_data_req, d_w_last, d_w_data, d_b_ready  in  1/1/32/1  dcache write data and response ready.
- d_w_rdy, d_w_data_ready, d_b_valid  out  1/1/1  dcache write handshakes.
- arid, araddr, arlen, arsize, arvalid  out  4/32/8/3/1  AXI AR channel; arready in 1.
- rid, rdata, rlast, rvalid  in  4/32/1/1  AXI R channel; rready out 1.
- awid, awaddr, awlen, awsize, awvalid  out  4/32/8/3/1  AXI AW channel; awready in 1.
- wdata, wstrb, wlast, wvalid  out  32/4/1/1  AXI W channel; wready in 1.
- bid, bvalid  in  4/1  AXI B channel; bready out 1.
- Fixed outputs: arburst = awburst = 2'b01 (INCR); arlock/arcache/arprot and aw equivalents = 0.

Behaviour:
- Reset (rst=1, asynchronous):
  - Both FSMs go to IDLE.
  - All valid, rdy, ready and ret outputs = 0; all latched address, length, size and ID registers = 0.
- Read FSM, states RD_IDLE → RD_ADDR → RD_DATA → RD_IDLE:
  - RD_IDLE:
    - If d_r_req is high and not blocked, latch the dcache request and pulse d_r_rdy in the same cycle.
    - Otherwise, if i_r_req is high, latch the icache request and pulse i_r_rdy.
    - dcache has fixed priority. Go to RD_ADDR.
  - RD_ADDR: arvalid=1 with the latched fields. On arready go to RD_DATA.
  - RD_DATA:
    - Route rvalid/rdata/rlast to the owner selected by rid.
    - rready = owner's r_data_ready.
    - Go to RD_IDLE on rvalid & rready & rlast.
  - Only one read is outstanding. A rid not matching the owner is an error: hold rready=0.
- RAW block: a dcache read is blocked while the write FSM is not idle and d_r_addr[31:6] == latched awaddr[31:6]. It is released the cycle after the B handshake completes.
- Write FSM, states WR_IDLE → WR_ADDR → WR_DATA → WR_RESP → WR_IDLE:
  - WR_IDLE: on d_w_req, latch address/len/size, pulse d_w_rdy, go to WR_ADDR.
  - WR_ADDR: awvalid=1. On awready go to WR_DATA.
  - WR_DATA:
    - wvalid = d_w_data_req; wdata, wstrb and wlast pass straight through.
    - d_w_data_ready = wready.
    - Count beats; go to WR_RESP on wvalid & wready & wlast.
    - If the beat count reaches awlen+1 without wlast, force wlast=1 on that beat.
  - WR_RESP: d_b_valid = bvalid, bready = d_b_ready. Go to WR_IDLE on the handshake. bresp is ignored.
- The read and write FSMs run concurrently: a dcache miss refill may overlap a dirty-line writeback.
- Latency: request to arvalid is 1 cycle. R data passes combinationally (0-cycle).
- If arready and the transition into RD_ADDR coincide, arvalid still holds ≥1 cycle. AXI-valid stability applies: valid never drops before ready.
- Reset asserted mid-burst aborts both FSMs immediately. No recovery of partial bursts.

Decomposition:
- Shared package/header axi_defs.vh holds:
  - burst and size encodings;
  - ID constants;
  - RD_*/WR_* state encodings.
- Natural sub-module: axi_rd_arbiter (read FSM + priority + RAW check). The write path stays inline.

Test Plan:
- icache 16-beat read at 0x1C000040, arready after 2 cycles:
  - i_r_rdy pulses once; araddr=0x1C000040, arlen=15, arid=0;
  - 16 i_ret_valid beats, i_ret_last on beat 16.
- d_r_req and i_r_req in the same cycle:
  - dcache granted first (arid=1);
  - icache granted in the cycle after dcache's rlast.
- dcache writeback of line 0x00001000 (16 beats), then read of 0x00001004 while in WR_DATA:
  - d_r_rdy stays 0 until the cycle after bvalid&bready, then the read issues.
- Uncached 1-beat store, wstrb=4'b0011, with wready stalled 3 cycles:
  - wvalid held, wdata stable, wlast=1;
  - d_b_valid forwarded after bvalid.
- Refill read to 0x2000 overlapping a writeback to 0x3000:
  - both channels progress in parallel;
  - R beats go to the dcache only.
- rst pulsed mid read burst:
  - all outputs 0 within the same cycle;
  - a fresh request afterward completes normally.
